// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational ALU between two requesters: the pipeline (port 0)
// and a secondary requester (port 1). Exactly one transaction is in flight at
// a time. A grant latches the operation and operands. The ALU then sees stable
// inputs for one full cycle, and its result is registered. That result is
// offered back to the owning requester until that requester accepts it.
//
// Ports
//   clk                         single clock, rising edge
//   reset                       synchronous, active-high
//   req_valid[1:0]              per-requester request valid (bit0 pipeline)
//   req_ready[1:0]              per-requester accept, at most one bit high
//   req_op0 / req_op1           4-bit ALU control code of each requester
//   req_a0, req_b0 / req_a1, req_b1  WIDTH-bit operands of each requester
//   alu_control, alu_a, alu_b   latched operation driven to the shared ALU
//   alu_result                  combinational result from the shared ALU
//   rsp_valid[1:0]              one-hot response valid to the owner
//   rsp_ready[1:0]              per-requester response accept
//   rsp_data                    registered ALU result (0 for unsupported ops)
//   rsp_err                     set when the accepted op code is unsupported
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [3:0]       req_op0,
  input  logic [3:0]       req_op1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic [3:0]       alu_control,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t           r_state;
  logic             r_lastGrant;
  logic             r_owner;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_rspValid;
  logic [WIDTH-1:0] r_rspData;
  logic             r_rspErr;

  logic [1:0]       w_grant;
  logic             w_accept;
  logic             w_acceptPort;
  logic             w_rspTaken;
  logic             w_supported;

  // Grant selection is only offered while idle and out of reset. With a single
  // valid requester, that requester wins. When both are valid, the port that
  // did not win last time is picked, so continuous contention alternates.
  always_comb begin
    w_grant = 2'b00;
    if (!reset && (r_state == IDLE)) begin
      case (req_valid)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11:   w_grant = r_lastGrant ? 2'b01 : 2'b10;
        default: w_grant = 2'b00;
      endcase
    end
  end

  assign req_ready    = w_grant;
  assign w_accept     = |(w_grant & req_valid);
  assign w_acceptPort = w_grant[1];

  // Only the owner's response-ready matters. The other bit is ignored, so a
  // stray accept from the wrong requester cannot retire the response.
  assign w_rspTaken = r_owner ? rsp_ready[1] : rsp_ready[0];

  // Decode of the op codes the shared ALU actually implements. Any other code
  // is answered with zero data and the error flag instead of the ALU output.
  always_comb begin
    w_supported = 1'b0;
    case (r_op)
      4'b0000, 4'b0001, 4'b0010, 4'b0100,
      4'b0110, 4'b0111, 4'b1000: w_supported = 1'b1;
      default:                   w_supported = 1'b0;
    endcase
  end

  // The latched operation feeds the ALU in every state. Because these latches
  // only move on acceptance or reset, the ALU inputs stay stable through EXEC
  // even if the requester changes its own operand lines.
  assign alu_control = r_op;
  assign alu_a       = r_a;
  assign alu_b       = r_b;

  assign rsp_valid = r_rspValid;
  assign rsp_data  = r_rspData;
  assign rsp_err   = r_rspErr;

  // Transaction FSM. IDLE waits for a handshake and latches the request. EXEC
  // gives the ALU one full cycle and captures its result. RESP holds the
  // response until the owner takes it. Reset wins over any handshake on the
  // same edge and drops an in-flight transaction without responding. The
  // reset value of last_grant lets port 0 win the first contention.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_lastGrant <= 1'b1;
      r_owner     <= 1'b0;
      r_op        <= 4'b0010;
      r_a         <= '0;
      r_b         <= '0;
      r_rspValid  <= 2'b00;
      r_rspData   <= '0;
      r_rspErr    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_owner     <= w_acceptPort;
            r_lastGrant <= w_acceptPort;
            r_op        <= w_acceptPort ? req_op1 : req_op0;
            r_a         <= w_acceptPort ? req_a1  : req_a0;
            r_b         <= w_acceptPort ? req_b1  : req_b0;
            r_state     <= EXEC;
          end
        end
        EXEC: begin
          r_rspData  <= w_supported ? alu_result : '0;
          r_rspErr   <= ~w_supported;
          r_rspValid <= r_owner ? 2'b10 : 2'b01;
          r_state    <= RESP;
        end
        RESP: begin
          if (w_rspTaken) begin
            r_rspValid <= 2'b00;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_rspValid <= 2'b00;
          r_state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Self-checking bench for alu_arbiter. It provides a behavioural shared ALU.
// It runs a table of single-requester vectors, then hand-written sequences for
// reset-in-EXEC and round-robin contention, then randomized traffic. The
// randomized traffic is checked against a grant/result model kept in the bench.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [3:0]       req_op0;
  logic [3:0]       req_op1;
  logic [WIDTH-1:0] req_a0;
  logic [WIDTH-1:0] req_b0;
  logic [WIDTH-1:0] req_a1;
  logic [WIDTH-1:0] req_b1;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op0     (req_op0),
    .req_op1     (req_op1),
    .req_a0      (req_a0),
    .req_b0      (req_b0),
    .req_a1      (req_a1),
    .req_b1      (req_b1),
    .alu_control (alu_control),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err)
  );

  // Behavioural shared ALU. Unsupported codes return a recognisable junk
  // value, so that forwarding it instead of zero is visible.
  function automatic logic [WIDTH-1:0] aluRef(input logic [3:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    case (op)
      4'h0:    return a | b;
      4'h1:    return a & b;
      4'h2:    return a + b;
      4'h4:    return a ^ b;
      4'h6:    return a - b;
      4'h7:    return ($signed(a) < $signed(b)) ? 1 : 0;
      4'h8:    return (a == b) ? 1 : 0;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_result = aluRef(alu_control, alu_a, alu_b);

  // Supported op codes as a bit mask indexed by the code itself.
  localparam logic [15:0] SUPPORTED_MASK = 16'b0000_0001_1101_0111;

  function automatic logic isSupported(input logic [3:0] op);
    return SUPPORTED_MASK[op];
  endfunction

  function automatic logic [WIDTH-1:0] expectedData(input logic [3:0] op,
                                                    input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
    return isSupported(op) ? aluRef(op, a, b) : '0;
  endfunction

  // One comparison: counts it and reports a mismatch (4-state aware).
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    reset     = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Runs one complete transaction, starting at posedge+1 with the FSM idle.
  // A stall of N cycles holds rsp_ready on the non-owner bit only, with both
  // request lines raised, so the response must not retire and no new grant
  // may appear.
  task automatic applyStimulus(input logic [1:0] valid,
                               input logic [3:0] op0, input logic [WIDTH-1:0] a0,
                               input logic [WIDTH-1:0] b0,
                               input logic [3:0] op1, input logic [WIDTH-1:0] a1,
                               input logic [WIDTH-1:0] b1,
                               input int stall, input int expPort,
                               input logic [WIDTH-1:0] expData, input logic expErr,
                               input string tag);
    int         waited;
    logic [1:0] oneHot;
    oneHot    = (expPort == 1) ? 2'b10 : 2'b01;
    req_valid = valid;
    req_op0   = op0;
    req_a0    = a0;
    req_b0    = b0;
    req_op1   = op1;
    req_a1    = a1;
    req_b1    = b1;
    rsp_ready = 2'b00;
    #1;
    waited = 0;
    while (((req_ready & req_valid) == 2'b00) && (waited < 8)) begin
      @(posedge clk);
      #1;
      waited++;
    end
    checkOutput({tag, ":grantWait"}, waited, 0);
    checkOutput({tag, ":req_ready"}, req_ready, oneHot);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    req_a0    = ~a0;
    req_b0    = ~b0;
    req_a1    = ~a1;
    req_b1    = ~b1;
    #1;
    checkOutput({tag, ":alu_control"}, alu_control, (expPort == 1) ? op1 : op0);
    checkOutput({tag, ":alu_a"}, alu_a, (expPort == 1) ? a1 : a0);
    checkOutput({tag, ":alu_b"}, alu_b, (expPort == 1) ? b1 : b0);
    checkOutput({tag, ":execValid"}, rsp_valid, 2'b00);
    @(posedge clk);
    #1;
    checkOutput({tag, ":rsp_valid"}, rsp_valid, oneHot);
    checkOutput({tag, ":rsp_data"}, rsp_data, expData);
    checkOutput({tag, ":rsp_err"}, rsp_err, expErr);
    for (int s = 0; s < stall; s++) begin
      req_valid = 2'b11;
      rsp_ready = ~oneHot;
      @(posedge clk);
      #1;
      checkOutput({tag, ":stallValid"}, rsp_valid, oneHot);
      checkOutput({tag, ":stallData"}, rsp_data, expData);
      checkOutput({tag, ":stallErr"}, rsp_err, expErr);
      checkOutput({tag, ":stallReady"}, req_ready, 2'b00);
    end
    req_valid = 2'b00;
    rsp_ready = oneHot;
    @(posedge clk);
    #1;
    rsp_ready = 2'b00;
    checkOutput({tag, ":retired"}, rsp_valid, 2'b00);
  endtask

  typedef struct {
    int               port;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    int               stall;
    logic [WIDTH-1:0] expData;
    logic             expErr;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int         grants[$];
    int         overlap;
    int         spurious;
    int         modelLast;
    int         port;
    int         stall;
    logic [1:0] valid;
    logic [3:0] op0;
    logic [3:0] op1;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;

    vecs[0] = '{0, 4'h2, 32'd5,        32'd7,    0, 32'd12,   1'b0};
    vecs[1] = '{1, 4'h3, 32'd3,        32'd4,    0, 32'd0,    1'b1};
    vecs[2] = '{0, 4'h2, 32'hFFFFFFFF, 32'd1,    5, 32'd0,    1'b0};
    vecs[3] = '{1, 4'h6, 32'd10,       32'd3,    0, 32'd7,    1'b0};
    vecs[4] = '{0, 4'h7, 32'hFFFFFFFF, 32'd1,    1, 32'd1,    1'b0};
    vecs[5] = '{1, 4'h0, 32'h000000F0, 32'h0F,   0, 32'hFF,   1'b0};
    vecs[6] = '{0, 4'h1, 32'h000000F0, 32'h3C,   2, 32'h30,   1'b0};
    vecs[7] = '{1, 4'h4, 32'h000000FF, 32'h0F,   3, 32'hF0,   1'b0};
    vecs[8] = '{0, 4'h8, 32'd9,        32'd9,    0, 32'd1,    1'b0};
    vecs[9] = '{1, 4'hF, 32'd1,        32'd1,    0, 32'd0,    1'b1};

    req_op0 = 4'h0;
    req_op1 = 4'h0;
    req_a0  = '0;
    req_b0  = '0;
    req_a1  = '0;
    req_b1  = '0;

    // Reset state, with both requesters asking during reset.
    reset     = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset:req_ready", req_ready, 2'b00);
    checkOutput("reset:alu_control", alu_control, 4'b0010);
    checkOutput("reset:alu_a", alu_a, 0);
    checkOutput("reset:alu_b", alu_b, 0);
    checkOutput("reset:rsp_valid", rsp_valid, 2'b00);
    checkOutput("reset:rsp_data", rsp_data, 0);
    checkOutput("reset:rsp_err", rsp_err, 1'b0);
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    reset     = 1'b0;

    // Table of single-requester vectors.
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].port == 0)
        applyStimulus(2'b01, vecs[i].op, vecs[i].a, vecs[i].b, 4'h2, 32'd100, 32'd200,
                      vecs[i].stall, 0, vecs[i].expData, vecs[i].expErr,
                      $sformatf("vec%0d", i));
      else
        applyStimulus(2'b10, 4'h2, 32'd100, 32'd200, vecs[i].op, vecs[i].a, vecs[i].b,
                      vecs[i].stall, 1, vecs[i].expData, vecs[i].expErr,
                      $sformatf("vec%0d", i));
    end

    // Reset while port 0's transaction is in EXEC: no response may follow,
    // and port 0 must win the next contention even though it won last.
    req_valid = 2'b01;
    req_op0   = 4'h2;
    req_a0    = 32'd1;
    req_b0    = 32'd2;
    #1;
    checkOutput("rstExec:req_ready", req_ready, 2'b01);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    reset     = 1'b1;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    spurious = 0;
    for (int c = 0; c < 6; c++) begin
      if (rsp_valid != 2'b00) spurious++;
      @(posedge clk);
      #1;
    end
    checkOutput("rstExec:noResponse", spurious, 0);

    // Continuous contention: grants must alternate starting at port 0.
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    req_op0   = 4'h2;
    req_op1   = 4'h6;
    overlap   = 0;
    grants.delete();
    #1;
    for (int c = 0; c < 40; c++) begin
      if (req_ready == 2'b11) overlap++;
      if ((req_ready & req_valid) != 2'b00) grants.push_back(req_ready[1] ? 1 : 0);
      if (grants.size() == 4) break;
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    rsp_ready = 2'b00;
    checkOutput("rr:grantCount", grants.size(), 4);
    checkOutput("rr:overlap", overlap, 0);
    for (int g = 0; g < 4; g++) begin
      if (g < grants.size())
        checkOutput($sformatf("rr:grant%0d", g), grants[g], g % 2);
    end

    // Randomized traffic against the grant/result model.
    doReset();
    modelLast = 1;
    for (int t = 0; t < 150; t++) begin
      valid = 2'($urandom_range(1, 3));
      op0   = 4'($urandom_range(0, 15));
      op1   = 4'($urandom_range(0, 15));
      a0    = $urandom;
      b0    = $urandom;
      a1    = $urandom;
      b1    = $urandom;
      stall = $urandom_range(0, 3);
      if (valid == 2'b01)      port = 0;
      else if (valid == 2'b10) port = 1;
      else                     port = (modelLast == 1) ? 0 : 1;
      applyStimulus(valid, op0, a0, b0, op1, a1, b1, stall, port,
                    (port == 1) ? expectedData(op1, a1, b1) : expectedData(op0, a0, b0),
                    (port == 1) ? ~isSupported(op1) : ~isSupported(op0),
                    $sformatf("rand%0d", t));
      modelLast = port;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
